// File: rtl/mem_arbiter.sv
// Round-robin arbiter between an instruction-fetch port and a data port that
// share one address-decode unit. Each request runs IDLE/RESP -> ACCESS -> RESP,
// so a new request can be accepted in the RESP cycle of the previous one.
module mem_arbiter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_ready,
   output logic        i_rvalid,
   output logic [31:0] i_rdata,
   output logic        i_fault,
   output logic        i_misaligned,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [1:0]  d_unit,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wd,
   output logic        d_ready,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        d_fault,
   output logic        d_misaligned,
   output logic        m_re,
   output logic        m_we,
   output logic [1:0]  m_rd_unit,
   output logic [1:0]  m_wd_unit,
   output logic [31:0] m_addr,
   output logic [31:0] m_wd,
   input  logic [31:0] m_rd,
   input  logic        m_access_fault,
   input  logic        m_addr_misaligned
);

   typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

   state_t      state_q, state_d;
   logic        last_d_q, last_d_d;   // 1: data port won the last acceptance
   logic        port_d_q, port_d_d;   // 1: in-flight request belongs to data port
   logic        we_q, we_d;
   logic [1:0]  unit_q, unit_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wd_q, wd_d;
   logic        i_rvalid_q, i_rvalid_d;
   logic [31:0] i_rdata_q, i_rdata_d;
   logic        i_fault_q, i_fault_d;
   logic        i_mis_q, i_mis_d;
   logic        d_rvalid_q, d_rvalid_d;
   logic [31:0] d_rdata_q, d_rdata_d;
   logic        d_fault_q, d_fault_d;
   logic        d_mis_q, d_mis_d;
   logic        can_accept;
   logic        grant_i;
   logic        grant_d;

   // Round-robin grant; readies are held low while reset is asserted
   always_comb begin
      can_accept = rst_n && (state_q != ST_ACCESS);
      grant_d    = can_accept && d_req && (!i_req || !last_d_q);
      grant_i    = can_accept && i_req && (!d_req || last_d_q);
      i_ready    = grant_i;
      d_ready    = grant_d;
   end

   // Next-state logic: ACCESS always lasts exactly one cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_RESP: state_d = (grant_i || grant_d) ? ST_ACCESS : ST_IDLE;
         ST_ACCESS:        state_d = ST_RESP;
         default:          state_d = ST_IDLE;
      endcase
   end

   // Latch the accepted request and move the round-robin pointer on acceptance
   always_comb begin
      last_d_d = last_d_q;
      port_d_d = port_d_q;
      we_d     = we_q;
      unit_d   = unit_q;
      addr_d   = addr_q;
      wd_d     = wd_q;
      if (grant_d) begin
         last_d_d = 1'b1;
         port_d_d = 1'b1;
         we_d     = d_we;
         unit_d   = d_unit;
         addr_d   = d_addr;
         wd_d     = d_wd;
      end else if (grant_i) begin
         last_d_d = 1'b0;
         port_d_d = 1'b0;
         we_d     = 1'b0;
         unit_d   = 2'b10;
         addr_d   = i_addr;
         wd_d     = 32'h0;
      end
   end

   // Capture decode results into the owning port's response registers
   always_comb begin
      i_rvalid_d = 1'b0;
      i_rdata_d  = i_rdata_q;
      i_fault_d  = i_fault_q;
      i_mis_d    = i_mis_q;
      d_rvalid_d = 1'b0;
      d_rdata_d  = d_rdata_q;
      d_fault_d  = d_fault_q;
      d_mis_d    = d_mis_q;
      if (state_q == ST_ACCESS) begin
         if (port_d_q) begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = we_q ? 32'h0 : m_rd;
            d_fault_d  = m_access_fault;
            d_mis_d    = m_addr_misaligned;
         end else begin
            i_rvalid_d = 1'b1;
            i_rdata_d  = m_rd;
            i_fault_d  = m_access_fault;
            i_mis_d    = m_addr_misaligned;
         end
      end
   end

   // State register; reset drops any in-flight request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         last_d_q   <= 1'b0;
         port_d_q   <= 1'b0;
         we_q       <= 1'b0;
         unit_q     <= 2'b00;
         addr_q     <= 32'h0;
         wd_q       <= 32'h0;
         i_rvalid_q <= 1'b0;
         i_rdata_q  <= 32'h0;
         i_fault_q  <= 1'b0;
         i_mis_q    <= 1'b0;
         d_rvalid_q <= 1'b0;
         d_rdata_q  <= 32'h0;
         d_fault_q  <= 1'b0;
         d_mis_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_d_q   <= last_d_d;
         port_d_q   <= port_d_d;
         we_q       <= we_d;
         unit_q     <= unit_d;
         addr_q     <= addr_d;
         wd_q       <= wd_d;
         i_rvalid_q <= i_rvalid_d;
         i_rdata_q  <= i_rdata_d;
         i_fault_q  <= i_fault_d;
         i_mis_q    <= i_mis_d;
         d_rvalid_q <= d_rvalid_d;
         d_rdata_q  <= d_rdata_d;
         d_fault_q  <= d_fault_d;
         d_mis_q    <= d_mis_d;
      end
   end

   // Decode-unit drive: only active in ACCESS, zero otherwise
   always_comb begin
      m_re      = 1'b0;
      m_we      = 1'b0;
      m_rd_unit = 2'b00;
      m_wd_unit = 2'b00;
      m_addr    = 32'h0;
      m_wd      = 32'h0;
      if (state_q == ST_ACCESS) begin
         m_re      = !we_q;
         m_we      = we_q;
         m_rd_unit = unit_q;
         m_wd_unit = unit_q;
         m_addr    = addr_q;
         m_wd      = wd_q;
      end
   end

   // Response outputs straight from registers
   always_comb begin
      i_rvalid     = i_rvalid_q;
      i_rdata      = i_rdata_q;
      i_fault      = i_fault_q;
      i_misaligned = i_mis_q;
      d_rvalid     = d_rvalid_q;
      d_rdata      = d_rdata_q;
      d_fault      = d_fault_q;
      d_misaligned = d_mis_q;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed requests, response scoreboard checked by a
// negedge monitor whenever an rvalid appears.
module tb_mem_arbiter;

   logic        clk;
   logic        rst_n;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_ready, i_rvalid, i_fault, i_misaligned;
   logic [31:0] i_rdata;
   logic        d_req, d_we;
   logic [1:0]  d_unit;
   logic [31:0] d_addr, d_wd;
   logic        d_ready, d_rvalid, d_fault, d_misaligned;
   logic [31:0] d_rdata;
   logic        m_re, m_we;
   logic [1:0]  m_rd_unit, m_wd_unit;
   logic [31:0] m_addr, m_wd;
   logic [31:0] dec_rd;
   logic        dec_fault, dec_mis;

   int errors = 0;
   int checks = 0;

   typedef struct {
      bit        is_d;
      bit [31:0] data;
      bit        fault;
      bit        mis;
   } resp_t;

   resp_t exp_q[$];

   mem_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rvalid(i_rvalid),
      .i_rdata(i_rdata), .i_fault(i_fault), .i_misaligned(i_misaligned),
      .d_req(d_req), .d_we(d_we), .d_unit(d_unit), .d_addr(d_addr), .d_wd(d_wd),
      .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_fault(d_fault),
      .d_misaligned(d_misaligned),
      .m_re(m_re), .m_we(m_we), .m_rd_unit(m_rd_unit), .m_wd_unit(m_wd_unit),
      .m_addr(m_addr), .m_wd(m_wd),
      .m_rd(dec_rd), .m_access_fault(dec_fault), .m_addr_misaligned(dec_mis)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
      end else begin
         $display("ok   %s: 0x%08h at %0t", tag, got, $time);
      end
   endtask

   task automatic push(input bit is_d, input bit [31:0] data, input bit flt, input bit mis);
      resp_t r;
      r.is_d = is_d; r.data = data; r.fault = flt; r.mis = mis;
      exp_q.push_back(r);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Response monitor: every rvalid must match the oldest expected response
   always @(negedge clk) begin
      if (i_ready && d_ready) check("ready_excl", {i_ready, d_ready}, 32'h0);
      if (i_rvalid || d_rvalid) begin
         if (exp_q.size() == 0) begin
            check("unexp_rvalid", {30'h0, i_rvalid, d_rvalid}, 32'h0);
         end else begin
            resp_t e;
            e = exp_q.pop_front();
            check("rv_port", {30'h0, i_rvalid, d_rvalid}, e.is_d ? 32'h1 : 32'h2);
            check("rdata", e.is_d ? d_rdata : i_rdata, e.data);
            check("fault", e.is_d ? {31'h0, d_fault} : {31'h0, i_fault}, {31'h0, e.fault});
            check("misal", e.is_d ? {31'h0, d_misaligned} : {31'h0, i_misaligned}, {31'h0, e.mis});
         end
      end
   end

   // One complete single-port transaction; entered just after a rising edge
   task automatic issue(input bit is_d, input bit we, input bit [1:0] unit,
                        input bit [31:0] addr, input bit [31:0] wd,
                        input bit [31:0] rd, input bit flt, input bit mis);
      dec_rd = rd; dec_fault = flt; dec_mis = mis;
      if (is_d) begin
         d_req = 1'b1; d_we = we; d_unit = unit; d_addr = addr; d_wd = wd;
      end else begin
         i_req = 1'b1; i_addr = addr;
      end
      @(negedge clk);
      check("i_ready", {31'h0, i_ready}, {31'h0, !is_d});
      check("d_ready", {31'h0, d_ready}, {31'h0, is_d});
      push(is_d, we ? 32'h0 : rd, flt, mis);
      next_cycle();
      i_req = 1'b0; d_req = 1'b0;
      @(negedge clk);
      check("m_re", {31'h0, m_re}, {31'h0, !we});
      check("m_we", {31'h0, m_we}, {31'h0, we});
      check("m_addr", m_addr, addr);
      if (we) begin
         check("m_wd_unit", {30'h0, m_wd_unit}, {30'h0, unit});
         check("m_wd", m_wd, wd);
      end else begin
         check("m_rd_unit", {30'h0, m_rd_unit}, is_d ? {30'h0, unit} : 32'h2);
      end
      next_cycle();
      @(negedge clk);   // response cycle, checked by the monitor
      next_cycle();
   endtask

   initial begin
      rst_n = 1'b1;
      i_req = 1'b1; i_addr = 32'h40;
      d_req = 1'b1; d_we = 1'b0; d_unit = 2'b10; d_addr = 32'h80; d_wd = 32'h0;
      dec_rd = 32'hCAFE0001; dec_fault = 1'b0; dec_mis = 1'b0;
      #2 rst_n = 1'b0;
      @(negedge clk);
      check("rst_i_ready", {31'h0, i_ready}, 32'h0);
      check("rst_d_ready", {31'h0, d_ready}, 32'h0);
      check("rst_m_re", {31'h0, m_re}, 32'h0);
      check("rst_m_addr", m_addr, 32'h0);
      check("rst_rvalid", {30'h0, i_rvalid, d_rvalid}, 32'h0);
      check("rst_d_rdata", d_rdata, 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Both ports held: D, I, D, I on cycles 0, 2, 4, 6
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (c % 2 == 0) begin
            check("tie_d_ready", {31'h0, d_ready}, (c % 4 == 0) ? 32'h1 : 32'h0);
            check("tie_i_ready", {31'h0, i_ready}, (c % 4 == 0) ? 32'h0 : 32'h1);
            push(c % 4 == 0, 32'hCAFE0001, 1'b0, 1'b0);
         end else begin
            check("tie_acc_ready", {30'h0, i_ready, d_ready}, 32'h0);
            check("tie_m_addr", m_addr, (c % 4 == 1) ? 32'h80 : 32'h40);
         end
         next_cycle();
         if (c == 6) begin i_req = 1'b0; d_req = 1'b0; end
      end
      @(negedge clk);
      next_cycle();

      // Fetch 0x100 returning 0xDEADBEEF, then response data must hold
      issue(1'b0, 1'b0, 2'b10, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
      @(negedge clk);
      check("hold_rvalid", {31'h0, i_rvalid}, 32'h0);
      check("hold_rdata", i_rdata, 32'hDEADBEEF);
      next_cycle();

      // Byte store
      issue(1'b1, 1'b1, 2'b00, 32'h2003, 32'hAB, 32'h77777777, 1'b0, 1'b0);
      // Misaligned half load
      issue(1'b1, 1'b0, 2'b01, 32'h1001, 32'h0, 32'h12345678, 1'b0, 1'b1);

      // Faulting load, next fetch accepted in its RESP cycle
      d_req = 1'b1; d_we = 1'b0; d_unit = 2'b10; d_addr = 32'h300;
      dec_rd = 32'h1111; dec_fault = 1'b1; dec_mis = 1'b0;
      @(negedge clk);
      check("flt_d_ready", {31'h0, d_ready}, 32'h1);
      push(1'b1, 32'h1111, 1'b1, 1'b0);
      next_cycle();
      d_req = 1'b0;
      @(negedge clk);
      check("flt_m_re", {31'h0, m_re}, 32'h1);
      next_cycle();
      i_req = 1'b1; i_addr = 32'h400; dec_rd = 32'h2222; dec_fault = 1'b0;
      @(negedge clk);
      check("resp_i_ready", {31'h0, i_ready}, 32'h1);
      push(1'b0, 32'h2222, 1'b0, 1'b0);
      next_cycle();
      i_req = 1'b0;
      @(negedge clk);
      check("b2b_m_addr", m_addr, 32'h400);
      next_cycle();
      @(negedge clk);
      next_cycle();

      // Fetch pulsed only while a data access is in ACCESS: must be dropped
      d_req = 1'b1; d_we = 1'b0; d_unit = 2'b10; d_addr = 32'h500; dec_rd = 32'h5555;
      @(negedge clk);
      check("drop_d_ready", {31'h0, d_ready}, 32'h1);
      push(1'b1, 32'h5555, 1'b0, 1'b0);
      next_cycle();
      d_req = 1'b0; i_req = 1'b1; i_addr = 32'h600;
      @(negedge clk);
      check("drop_i_ready", {31'h0, i_ready}, 32'h0);
      next_cycle();
      i_req = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("drop_m_re", {31'h0, m_re}, 32'h0);
         next_cycle();
      end

      // Reset in ACCESS: m_re drops at once, no response afterwards
      d_req = 1'b1; d_addr = 32'h700; dec_rd = 32'h7777;
      @(negedge clk);
      check("rst_acc_ready", {31'h0, d_ready}, 32'h1);
      next_cycle();
      d_req = 1'b0;
      @(negedge clk);
      check("rst_acc_m_re", {31'h0, m_re}, 32'h1);
      #1 rst_n = 1'b0;
      #1;
      check("async_m_re", {31'h0, m_re}, 32'h0);
      check("async_m_addr", m_addr, 32'h0);
      next_cycle();
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("post_rst_rvalid", {30'h0, i_rvalid, d_rvalid}, 32'h0);
         next_cycle();
      end

      check("queue_empty", exp_q.size(), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Time limit so the run always ends
   initial begin
      #200000;
      $display("FAIL timeout: got=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
